// File: rtl/bus_arbiter_pkg.sv
// Shared types for the two-port bus arbiter: FSM state, request/response payloads
// and the default response timeout.
package bus_arbiter_pkg;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int NPORT_DEFAULT   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  wstrb;
    } bus_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } bus_resp_t;

    function automatic logic [1:0] port_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_arbiter.sv
// Two-input round-robin grant: on a tie the port not granted last wins.
// The last-grant register only moves when the caller accepts a grant.
module rr_arbiter
    import bus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic last_q;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave a value unassigned and infer a latch.
    always_comb begin
        grant_id = 1'b0;
        grant    = 2'b00;
        if (req == 2'b11) begin
            grant_id = ~last_q;
        end else begin
            grant_id = req[1];
        end
        if (req != 2'b00) begin
            grant = port_onehot(grant_id);
        end
    end

    // NOTE: state is updated with non-blocking assignments only, and the reset
    // is synchronous (sampled at the clock edge), so it sits inside the edge block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= 1'b0;
        end else if (accept && (req != 2'b00)) begin
            last_q <= grant_id;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-port (ifetch / dmem) arbiter in front of the l2cache: one transaction in
// flight, IDLE -> ISSUE -> WAIT, with a response timeout and spurious-response flag.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int NPORT   = NPORT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT-1:0]       m_req_valid,
    output logic [NPORT-1:0]       m_req_ready,
    input  logic [NPORT-1:0][31:0] m_req_addr,
    input  logic [NPORT-1:0][31:0] m_req_wdata,
    input  logic [NPORT-1:0]       m_req_we,
    input  logic [NPORT-1:0][3:0]  m_req_wstrb,
    output logic [NPORT-1:0]       m_resp_valid,
    output logic [31:0]            m_resp_rdata,
    output logic                   m_resp_err,
    output logic                   s_req_valid,
    input  logic                   s_req_ready,
    output logic [31:0]            s_req_addr,
    output logic                   s_req_we,
    output logic [31:0]            s_req_wdata,
    output logic [3:0]             s_req_wstrb,
    input  logic                   s_resp_valid,
    input  logic [31:0]            s_resp_rdata,
    input  logic                   s_resp_err,
    output logic                   timeout_err,
    output logic                   spurious_err
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    arb_state_t       state_q;
    logic             owner_q;
    bus_req_t         req_q;
    logic [CNT_W-1:0] wait_cnt_q;

    logic       in_idle;
    logic       in_wait;
    logic [1:0] arb_req;
    logic [1:0] arb_grant;
    logic       arb_grant_id;
    logic       timeout_hit;
    logic       resp_fwd;
    logic       resp_tmo;
    bus_req_t   sel_req;
    bus_resp_t  resp;

    rr_arbiter u_rr (
        .clk      (clk),
        .rst      (rst),
        .req      (arb_req),
        .accept   (in_idle),
        .grant    (arb_grant),
        .grant_id (arb_grant_id)
    );

    // All handshake outputs are gated by rst so they read 0 for the whole reset cycle.
    always_comb begin
        in_idle     = rst && (state_q == ST_IDLE);
        in_wait     = rst && (state_q == ST_WAIT);
        arb_req     = m_req_valid & {2{in_idle}};
        timeout_hit = (wait_cnt_q == TIMEOUT_CNT);
        resp_fwd    = in_wait && s_resp_valid;
        resp_tmo    = in_wait && !s_resp_valid && timeout_hit;

        sel_req.addr  = m_req_addr[arb_grant_id];
        sel_req.wdata = m_req_wdata[arb_grant_id];
        sel_req.we    = m_req_we[arb_grant_id];
        sel_req.wstrb = m_req_wstrb[arb_grant_id];

        resp = '0;
        if (resp_fwd) begin
            resp.rdata = s_resp_rdata;
            resp.err   = s_resp_err;
        end else if (resp_tmo) begin
            resp.err = 1'b1;
        end

        m_req_ready  = arb_grant;
        m_resp_valid = (resp_fwd || resp_tmo) ? port_onehot(owner_q) : '0;
        m_resp_rdata = resp.rdata;
        m_resp_err   = resp.err;
        timeout_err  = resp_tmo;
        spurious_err = rst && s_resp_valid && (state_q != ST_WAIT);

        s_req_valid = rst && (state_q == ST_ISSUE);
        s_req_addr  = req_q.addr;
        s_req_we    = req_q.we;
        s_req_wdata = req_q.wdata;
        s_req_wstrb = req_q.wstrb;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            req_q      <= '0;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_grant != 2'b00) begin
                        req_q   <= sel_req;
                        owner_q <= arb_grant_id;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (s_req_ready) begin
                        wait_cnt_q <= '0;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A response on the timeout cycle wins; either way the slot frees up.
                    if (s_resp_valid || timeout_hit) begin
                        wait_cnt_q <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum number of WAIT cycles before the owner receives an error response.
REQ-002 SHALL have parameter NPORT, default 2, giving the number of upstream ports (port 0 = instruction fetch, port 1 = data memory); the value is fixed at 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset; the block is in reset when rst=0 at a clk edge.
REQ-005 SHALL have ports m_req_valid and m_req_ready, input and output, [NPORT-1:0]: per-port request handshake.
REQ-006 SHALL have ports m_req_addr, m_req_wdata (input, NPORT x 32), m_req_we (input, [NPORT-1:0]) and m_req_wstrb (input, NPORT x 4): per-port request payload.
REQ-007 SHALL have ports m_resp_valid (output, [NPORT-1:0]), m_resp_rdata (output, 32) and m_resp_err (output, 1): response to the owning port; rdata and err are shared across ports.
REQ-008 SHALL have ports s_req_valid (output, 1), s_req_ready (input, 1), s_req_addr (output, 32), s_req_we (output, 1), s_req_wdata (output, 32) and s_req_wstrb (output, 4): downstream request to l2cache.
REQ-009 SHALL have ports s_resp_valid (input, 1), s_resp_rdata (input, 32) and s_resp_err (input, 1): downstream response.
REQ-010 SHALL have port timeout_err, output, 1 bit: one-cycle pulse when a transaction times out.
REQ-011 SHALL have port spurious_err, output, 1 bit: one-cycle pulse when a response arrives outside WAIT.

Function
REQ-012 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE, with at most one outstanding transaction.
REQ-013 IDLE: if any m_req_valid, SHALL assert m_req_ready for the winner only (combinational, same cycle), latch the winner payload and owner id, and go to ISSUE.
REQ-014 Arbitration SHALL be round-robin: when both ports request, the port not granted last wins; after reset the last-granted port is 0, so port 1 wins the first tie.
REQ-015 ISSUE: SHALL hold s_req_valid=1 with the latched payload stable until s_req_ready=1, then go to WAIT; m_req_valid changes SHALL NOT affect the latched payload.
REQ-016 WAIT: on s_resp_valid, SHALL drive m_resp_valid[owner]=1 in the same cycle, with m_resp_rdata=s_resp_rdata and m_resp_err=s_resp_err, then go to IDLE.
REQ-017 WAIT: SHALL count cycles from 0; when the count reaches TIMEOUT with no response, SHALL pulse m_resp_valid[owner] with m_resp_err=1, m_resp_rdata=0 and timeout_err=1, then go to IDLE.
REQ-018 s_resp_valid in IDLE or ISSUE SHALL be dropped, SHALL pulse spurious_err, and SHALL leave the state unchanged.
REQ-019 A response in the same cycle as the timeout SHALL take priority: it is forwarded normally and timeout_err is not raised.
REQ-020 m_req_ready SHALL be 0 outside IDLE; a new grant SHALL be possible in the first IDLE cycle after a response, giving a best-case throughput of one transaction per 3 cycles.
REQ-021 Non-owner m_resp_valid bits SHALL be 0 at all times.

Reset
REQ-022 When rst=0: state=IDLE, last-granted port=0, wait counter=0, latched payload=0, and all outputs 0 (s_req_valid, m_req_ready, m_resp_valid, m_resp_err, timeout_err, spurious_err).
REQ-023 Reset asserted in ISSUE or WAIT SHALL abandon the transaction with no response to the owner; a late downstream response SHALL then raise spurious_err.

Structure
REQ-024 The arbiter state enum, the BusReq/BusResp payload structs and the TIMEOUT default SHALL live in the shared common package.
REQ-025 A single sub-module rr_arbiter (2-input round-robin grant logic with last-grant register) SHALL be used; all other logic stays in bus_arbiter.

Verification
REQ-026 Only port 0 requests addr 0x100, s_req_ready=1, response rdata 0xDEADBEEF 2 cycles later -> m_resp_valid=01, m_resp_rdata=0xDEADBEEF, err=0.
REQ-027 Both ports request continuously from reset -> grant order 1,0,1,0, and every downstream address matches its port's latched address.
REQ-028 Grant port 1 write (addr 0x2000, wdata 0x12345678, wstrb 0xF), hold s_req_ready=0 for 5 cycles -> s_req payload stable for all 5 cycles, m_req_ready=00.
REQ-029 TIMEOUT=8, no response -> exactly 8 WAIT cycles, then m_resp_err=1 to the owner and timeout_err pulses once; a response in the same cycle as the timeout is forwarded instead.
REQ-030 s_resp_valid while in IDLE -> spurious_err=1 for one cycle, m_resp_valid=00; rst=0 in WAIT -> IDLE next cycle with all outputs 0.
